// File: rtl/op_pkg.sv
// ---------------------------------------------------------------------------
// op_pkg
// Shared definitions for the operation initiator:
//   - OP_BW / OP_DEPTH : default operand width and operand FIFO depth
//   - op_state_e       : initiator FSM state encoding
// ---------------------------------------------------------------------------
package op_pkg;

    localparam int OP_BW    = 16;
    localparam int OP_DEPTH = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } op_state_e;

endpackage

// File: rtl/op_initiator_if.sv
// ---------------------------------------------------------------------------
// op_initiator_if
// Bundles the three handshakes around the initiator:
//   REQ_*  : upstream operand push (REQ_VALID/REQ_READY, REQ_A, REQ_B)
//   ST/IN0/IN1/RD/RES : start/ready operation block
//   RSP_*  : result handoff (RSP_VALID/RSP_READY, RSP_DATA, RSP_ERR)
// Modports:
//   master : the initiator itself (starts operations, produces responses)
//   slave  : its environment (operand source, operation block, result sink)
// ---------------------------------------------------------------------------
interface op_initiator_if import op_pkg::*; #(
    parameter int BW = OP_BW
);
    logic          REQ_VALID;
    logic          REQ_READY;
    logic [BW-1:0] REQ_A;
    logic [BW-1:0] REQ_B;

    logic          ST;
    logic [BW-1:0] IN0;
    logic [BW-1:0] IN1;
    logic          RD;
    logic [BW-1:0] RES;

    logic          RSP_VALID;
    logic          RSP_READY;
    logic [BW-1:0] RSP_DATA;
    logic          RSP_ERR;

    modport master (
        input  REQ_VALID, REQ_A, REQ_B, RD, RES, RSP_READY,
        output REQ_READY, ST, IN0, IN1, RSP_VALID, RSP_DATA, RSP_ERR
    );

    modport slave (
        output REQ_VALID, REQ_A, REQ_B, RD, RES, RSP_READY,
        input  REQ_READY, ST, IN0, IN1, RSP_VALID, RSP_DATA, RSP_ERR
    );

endinterface

// File: rtl/op_fifo.sv
// ---------------------------------------------------------------------------
// op_fifo
// Synchronous FIFO holding operand pairs.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write din when push and not full
//   pop, dout  : dout shows the head; pop advances it when not empty
//   full/empty : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable
// with DEPTH a power of two.
// ---------------------------------------------------------------------------
module op_fifo import op_pkg::*; #(
    parameter int W     = 2 * OP_BW,
    parameter int DEPTH = OP_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: empty pointers hide stale contents.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/op_initiator.sv
// ---------------------------------------------------------------------------
// op_initiator
// Queues operand pairs and drives them, one at a time, into a start/ready
// operation block, then hands each result downstream.
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : op_initiator_if.master (REQ_*, ST/IN0/IN1/RD/RES, RSP_*)
//   BUSY       : FSM not idle or operands still queued
// Optional feature (macro OP_INITIATOR_TIMEOUT_EN): a WAIT-cycle counter
// aborts an operation after TIMEOUT cycles without RD and returns an error
// response (RSP_ERR=1, RSP_DATA=0). Without the macro RSP_ERR is tied low
// and WAIT lasts until RD.
// ---------------------------------------------------------------------------
module op_initiator import op_pkg::*; #(
    parameter int BW      = OP_BW,
    parameter int DEPTH   = OP_DEPTH,
    parameter int TIMEOUT = 255
) (
    input  logic            CLK,
    input  logic            RST_N,
    op_initiator_if.master  bus,
    output logic            BUSY
);

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [2*BW-1:0] fifo_head;

    op_state_e     state_q, state_d;
    logic          st_q, st_d;
    logic [BW-1:0] in0_q, in0_d;
    logic [BW-1:0] in1_q, in1_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [BW-1:0] rsp_data_q, rsp_data_d;
    // Held low in reset so REQ_READY only rises on the first edge after release.
    logic          rdy_q, rdy_d;

`ifdef OP_INITIATOR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rsp_err_q, rsp_err_d;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    op_fifo #(
        .W     (2 * BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({bus.REQ_A, bus.REQ_B}),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Readiness depends only on fullness, so a pop never frees a slot
    // for a push in the same cycle.
    assign bus.REQ_READY = rdy_q && !fifo_full;
    assign fifo_push     = bus.REQ_VALID && bus.REQ_READY;

    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        in0_d       = in0_q;
        in1_d       = in1_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rdy_d       = 1'b1;
        fifo_pop    = 1'b0;
`ifdef OP_INITIATOR_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !rsp_valid_q) begin
                    fifo_pop = 1'b1;
                    in0_d    = fifo_head[2*BW-1:BW];
                    in1_d    = fifo_head[BW-1:0];
                    st_d     = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            // RD is deliberately not looked at here: it may still be the
            // previous operation's completion.
            S_ISSUE: begin
                st_d    = 1'b0;
                state_d = S_WAIT;
`ifdef OP_INITIATOR_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (bus.RD) begin
                    rsp_data_d  = bus.RES;
                    rsp_valid_d = 1'b1;
                    state_d     = S_HOLD;
`ifdef OP_INITIATOR_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_data_d  = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    cnt_d       = cnt_q + CW'(1);
`endif
                end
            end
            S_HOLD: begin
                if (bus.RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            st_q        <= 1'b0;
            in0_q       <= '0;
            in1_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rdy_q       <= 1'b0;
`ifdef OP_INITIATOR_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            in0_q       <= in0_d;
            in1_q       <= in1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rdy_q       <= rdy_d;
`ifdef OP_INITIATOR_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign bus.ST        = st_q;
    assign bus.IN0       = in0_q;
    assign bus.IN1       = in1_q;
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_DATA  = rsp_data_q;
`ifdef OP_INITIATOR_TIMEOUT_EN
    assign bus.RSP_ERR   = rsp_err_q;
`else
    assign bus.RSP_ERR   = 1'b0;
`endif
    assign BUSY          = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_op_initiator.sv
// ---------------------------------------------------------------------------
// tb_op_initiator
// Bench for op_initiator. The operation block is modelled as a multiplier
// (RES = IN0*IN1 truncated to BW bits) with random or fixed latency; the
// expected response stream is a queue of products in push order, with
// error entries for timed-out operations.
// ---------------------------------------------------------------------------
module tb_op_initiator;

    localparam int BW    = 16;
    localparam int DEPTH = 4;
    localparam int TO    = 8;

    typedef struct packed {
        logic          err;
        logic [BW-1:0] data;
    } rsp_t;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic BUSY;

    op_initiator_if #(.BW(BW)) bus();

    op_initiator #(
        .BW      (BW),
        .DEPTH   (DEPTH),
        .TIMEOUT (TO)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus),
        .BUSY  (BUSY)
    );

    always #5 CLK = ~CLK;

    int   n_vec = 0;
    int   n_err = 0;
    rsp_t exp_q[$];
    int   st_pulses = 0;

    // Operation-block and sink controls
    logic          opb_auto = 1'b0;
    int            opb_fix  = -1;
    logic          auto_rd  = 1'b0;
    logic [BW-1:0] auto_res = '0;
    logic          man_rd   = 1'b0;
    logic [BW-1:0] man_res  = '0;
    logic          rsp_rand = 1'b0;
    logic          rand_rdy = 1'b1;
    logic          man_rdy  = 1'b1;

    assign bus.RD        = opb_auto ? auto_rd  : man_rd;
    assign bus.RES       = opb_auto ? auto_res : man_res;
    assign bus.RSP_READY = rsp_rand ? rand_rdy : man_rdy;

    function automatic logic [BW-1:0] mul(input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic [2*BW-1:0] p;
        p = a * b;
        return p[BW-1:0];
    endfunction

    // Stimulus and checks happen 1 time unit after the falling edge.
    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    // Background: random sink readiness
    always begin
        @(negedge CLK);
        rand_rdy = 1'($urandom_range(0, 1));
    end

    // Background: ST pulse counter
    always begin
        @(negedge CLK);
        #2;
        if (bus.ST === 1'b1) st_pulses++;
    end

    // Background: response scoreboard, fires on each completed handshake
    always begin : collector
        rsp_t e;
        @(negedge CLK);
        #2;
        if (bus.RSP_VALID === 1'b1 && bus.RSP_READY === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rsp_unexpected: got data=%0h err=%0b, required no response",
                         bus.RSP_DATA, bus.RSP_ERR);
            end else begin
                e = exp_q.pop_front();
                if (bus.RSP_DATA !== e.data || bus.RSP_ERR !== e.err) begin
                    n_err++;
                    $display("FAIL rsp_data: got data=%0h err=%0b, required data=%0h err=%0b",
                             bus.RSP_DATA, bus.RSP_ERR, e.data, e.err);
                end
            end
        end
    end

    // Background: multiplier operation block (active when opb_auto)
    always begin : opb
        logic [BW-1:0] a, b;
        int d;
        tick();
        if (opb_auto && bus.ST === 1'b1) begin
            a = bus.IN0;
            b = bus.IN1;
            d = (opb_fix >= 0) ? opb_fix : int'($urandom_range(0, 12));
            tick();
            n_vec++;
            if (bus.ST !== 1'b0) begin
                n_err++;
                $display("FAIL st_width: ST got %0b in first WAIT cycle, required 0", bus.ST);
            end
            repeat (d) begin
                n_vec++;
                if (bus.IN0 !== a || bus.IN1 !== b) begin
                    n_err++;
                    $display("FAIL in_hold: got IN0=%0h IN1=%0h, required %0h %0h",
                             bus.IN0, bus.IN1, a, b);
                end
                tick();
            end
            auto_rd  = 1'b1;
            auto_res = mul(a, b);
            tick();
            auto_rd  = 1'b0;
            auto_res = BW'($urandom);
        end
    end

    // Push one pair; records the model entry when the DUT accepts it.
    task automatic push_pair(input logic [BW-1:0] a, input logic [BW-1:0] b,
                             output int waited, output logic st_at_accept);
        waited = 0;
        bus.REQ_VALID = 1'b1;
        bus.REQ_A = a;
        bus.REQ_B = b;
        while (bus.REQ_READY !== 1'b1 && waited < 300) begin
            tick();
            waited++;
        end
        st_at_accept = bus.ST;
        if (waited >= 300) begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout: REQ_READY got %0b, required 1", bus.REQ_READY);
        end else begin
            exp_q.push_back('{err: 1'b0, data: mul(a, b)});
        end
        tick();
        bus.REQ_VALID = 1'b0;
    endtask

    task automatic wait_st();
        int w = 0;
        while (bus.ST !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        if (w >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL st_timeout: ST got %0b, required 1", bus.ST);
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        while ((BUSY !== 1'b0 || bus.RSP_VALID !== 1'b0) && w < 3000) begin
            tick();
            w++;
        end
        tick();
        n_vec++;
        if (w >= 3000 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got BUSY=%0b pending=%0d, required BUSY=0 pending=0",
                     BUSY, exp_q.size());
        end
    endtask

    task automatic test_reset();
        bus.REQ_VALID = 1'b1;
        bus.REQ_A = 16'h0003;
        bus.REQ_B = 16'h0007;
        RST_N = 1'b0;
        repeat (3) tick();
        n_vec++;
        if ({bus.ST, bus.IN0, bus.IN1, bus.RSP_VALID, bus.RSP_DATA, bus.RSP_ERR, BUSY,
             bus.REQ_READY} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got ST=%0b IN0=%0h IN1=%0h V=%0b D=%0h E=%0b BUSY=%0b RDY=%0b, required all 0",
                     bus.ST, bus.IN0, bus.IN1, bus.RSP_VALID, bus.RSP_DATA, bus.RSP_ERR, BUSY,
                     bus.REQ_READY);
        end
        bus.REQ_VALID = 1'b0;
        RST_N = 1'b1;
        tick();
        n_vec++;
        if (bus.REQ_READY !== 1'b1 || BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got REQ_READY=%0b BUSY=%0b, required 1 0",
                     bus.REQ_READY, BUSY);
        end
    endtask

    task automatic test_single();
        int w;
        logic s;
        int st0;
        opb_auto = 1'b1;
        opb_fix = 10;
        st0 = st_pulses;
        push_pair(16'd4, 16'd5, w, s);
        n_vec++;
        if (bus.ST !== 1'b0) begin
            n_err++;
            $display("FAIL latency_n1: ST got %0b one cycle after push, required 0", bus.ST);
        end
        tick();
        n_vec++;
        if (bus.ST !== 1'b1 || bus.IN0 !== 16'd4 || bus.IN1 !== 16'd5) begin
            n_err++;
            $display("FAIL latency_n2: got ST=%0b IN0=%0h IN1=%0h, required 1 4 5",
                     bus.ST, bus.IN0, bus.IN1);
        end
        w = 0;
        while (bus.RSP_VALID !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        n_vec++;
        if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 16'd20 || bus.RSP_ERR !== 1'b0) begin
            n_err++;
            $display("FAIL single_rsp: got V=%0b D=%0d E=%0b, required 1 20 0",
                     bus.RSP_VALID, bus.RSP_DATA, bus.RSP_ERR);
        end
        wait_idle();
        n_vec++;
        if (st_pulses - st0 != 1) begin
            n_err++;
            $display("FAIL single_st_count: got %0d ST cycles, required 1", st_pulses - st0);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        logic s;
        opb_auto = 1'b1;
        opb_fix = 15;
        push_pair(16'h0011, 16'h0022, w, s);
        wait_st();
        for (int i = 0; i < 4; i++) begin
            push_pair(BW'($urandom), BW'($urandom), w, s);
        end
        n_vec++;
        if (bus.REQ_READY !== 1'b0) begin
            n_err++;
            $display("FAIL full_ready: REQ_READY got %0b with 4 queued, required 0", bus.REQ_READY);
        end
        push_pair(BW'($urandom), BW'($urandom), w, s);
        n_vec++;
        if (w == 0 || s !== 1'b1) begin
            n_err++;
            $display("FAIL fifth_push: got waited=%0d ST_at_accept=%0b, required waited>0 ST=1",
                     w, s);
        end
        opb_fix = -1;
        wait_idle();
    endtask

    task automatic test_backpressure();
        int w;
        logic s;
        logic [BW-1:0] d;
        int st0;
        opb_auto = 1'b1;
        opb_fix = -1;
        man_rdy = 1'b0;
        push_pair(BW'($urandom), BW'($urandom), w, s);
        push_pair(BW'($urandom), BW'($urandom), w, s);
        w = 0;
        while (bus.RSP_VALID !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        d = bus.RSP_DATA;
        st0 = st_pulses;
        repeat (20) begin
            tick();
            n_vec++;
            if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== d || bus.ST !== 1'b0) begin
                n_err++;
                $display("FAIL hold_stable: got V=%0b D=%0h ST=%0b, required 1 %0h 0",
                         bus.RSP_VALID, bus.RSP_DATA, bus.ST, d);
            end
        end
        n_vec++;
        if (st_pulses != st0) begin
            n_err++;
            $display("FAIL hold_no_issue: got %0d ST cycles in HOLD, required 0", st_pulses - st0);
        end
        man_rdy = 1'b1;
        wait_idle();
    endtask

    task automatic test_rd_held();
        int w;
        logic s;
        logic [BW-1:0] a1, b1, a2, b2;
        opb_auto = 1'b0;
        a1 = BW'($urandom); b1 = BW'($urandom);
        a2 = BW'($urandom); b2 = BW'($urandom);
        push_pair(a1, b1, w, s);
        push_pair(a2, b2, w, s);
        wait_st();
        tick();
        tick();
        man_rd = 1'b1;
        man_res = mul(a1, b1);
        tick();
        wait_st();
        // RD still high through ISSUE, carrying a wrong result
        man_res = ~mul(a2, b2);
        tick();
        man_rd = 1'b0;
        repeat (5) begin
            tick();
            n_vec++;
            if (bus.RSP_VALID !== 1'b0) begin
                n_err++;
                $display("FAIL rd_in_issue: RSP_VALID got %0b before new RD, required 0",
                         bus.RSP_VALID);
            end
        end
        man_rd = 1'b1;
        man_res = mul(a2, b2);
        tick();
        man_rd = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int w;
        logic s;
        logic [BW-1:0] a, b;
        opb_auto = 1'b0;
        a = BW'($urandom); b = BW'($urandom);
        push_pair(a, b, w, s);
        push_pair(BW'($urandom), BW'($urandom), w, s);
        wait_st();
        tick();
        tick();
        RST_N = 1'b0;
        exp_q.delete();
        #1;
        n_vec++;
        if ({bus.ST, bus.RSP_VALID, BUSY, bus.REQ_READY, bus.IN0, bus.IN1} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got ST=%0b V=%0b BUSY=%0b RDY=%0b IN0=%0h IN1=%0h, required all 0",
                     bus.ST, bus.RSP_VALID, BUSY, bus.REQ_READY, bus.IN0, bus.IN1);
        end
        tick();
        tick();
        RST_N = 1'b1;
        man_rd = 1'b1;
        man_res = mul(a, b);
        tick();
        man_rd = 1'b0;
        n_vec++;
        if (bus.REQ_READY !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset: got %0b, required 1", bus.REQ_READY);
        end
        repeat (8) begin
            tick();
            n_vec++;
            if (bus.RSP_VALID !== 1'b0 || bus.ST !== 1'b0 || BUSY !== 1'b0) begin
                n_err++;
                $display("FAIL post_reset_quiet: got V=%0b ST=%0b BUSY=%0b, required 0 0 0",
                         bus.RSP_VALID, bus.ST, BUSY);
            end
        end
    endtask

    task automatic test_random();
        int w;
        logic s;
        opb_auto = 1'b1;
        opb_fix = -1;
        rsp_rand = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push_pair(BW'($urandom), BW'($urandom), w, s);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle();
        rsp_rand = 1'b0;
    endtask

`ifdef OP_INITIATOR_TIMEOUT_EN
    task automatic test_timeout();
        int w;
        logic s;
        logic [BW-1:0] a, b;
        opb_auto = 1'b0;
        man_rd = 1'b0;
        push_pair(BW'($urandom), BW'($urandom), w, s);
        exp_q[exp_q.size() - 1] = '{err: 1'b1, data: '0};
        wait_st();
        for (int k = 1; k <= TO; k++) begin
            tick();
            n_vec++;
            if (bus.RSP_VALID !== 1'b0) begin
                n_err++;
                $display("FAIL timeout_early: RSP_VALID got %0b in WAIT cycle %0d, required 0",
                         bus.RSP_VALID, k);
            end
        end
        tick();
        n_vec++;
        if (bus.RSP_VALID !== 1'b1 || bus.RSP_ERR !== 1'b1 || bus.RSP_DATA !== '0) begin
            n_err++;
            $display("FAIL timeout_rsp: got V=%0b E=%0b D=%0h, required 1 1 0",
                     bus.RSP_VALID, bus.RSP_ERR, bus.RSP_DATA);
        end
        wait_idle();
        // RD on the expiry cycle wins
        a = BW'($urandom); b = BW'($urandom);
        push_pair(a, b, w, s);
        wait_st();
        for (int k = 1; k <= TO; k++) begin
            tick();
            if (k == TO) begin
                man_rd = 1'b1;
                man_res = mul(a, b);
            end
        end
        tick();
        man_rd = 1'b0;
        n_vec++;
        if (bus.RSP_VALID !== 1'b1 || bus.RSP_ERR !== 1'b0 || bus.RSP_DATA !== mul(a, b)) begin
            n_err++;
            $display("FAIL rd_precedence: got V=%0b E=%0b D=%0h, required 1 0 %0h",
                     bus.RSP_VALID, bus.RSP_ERR, bus.RSP_DATA, mul(a, b));
        end
        wait_idle();
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time got limit, required finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.REQ_VALID = 1'b0;
        bus.REQ_A = '0;
        bus.REQ_B = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_rd_held();
        test_reset_mid();
        test_random();
`ifdef OP_INITIATOR_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/op_initiator.md
OP_INITIATOR -- requirements
Module: op_initiator

Interface
REQ-001 SHALL have parameter BW, default 16: operand and result width.
REQ-002 SHALL have parameter DEPTH, default 4 (power of two, >=2): operand FIFO entries.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum WAIT cycles; used only with the timeout feature.
REQ-004 SHALL have port CLK in 1: single clock; all state changes on the rising edge.
REQ-005 SHALL have port RST_N in 1: reset, asynchronous, active-low.
REQ-006 SHALL have ports REQ_VALID in 1, REQ_READY out 1, REQ_A in BW, REQ_B in BW: upstream operand push.
REQ-007 SHALL have ports ST out 1, IN0 out BW, IN1 out BW, RD in 1, RES in BW: drive a start/ready operation block.
REQ-008 SHALL have ports RSP_VALID out 1, RSP_READY in 1, RSP_DATA out BW, RSP_ERR out 1: result handoff.
REQ-009 SHALL have port BUSY out 1: high when the FSM is not in IDLE or the FIFO is non-empty.

Function
REQ-010 SHALL buffer operand pairs in a DEPTH-entry FIFO; push on REQ_VALID&&REQ_READY; REQ_READY = !full.
REQ-011 SHALL not accept a push when the FIFO is full, even if a pop occurs in the same cycle.
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT and HOLD.
REQ-013 SHALL move IDLE->ISSUE when the FIFO is non-empty and RSP_VALID is low, popping the head into IN0/IN1.
REQ-014 SHALL assert ST for exactly one cycle in ISSUE, then go to WAIT.
REQ-015 SHALL keep IN0/IN1 stable from ISSUE until the WAIT exit.
REQ-016 SHALL ignore RD in ISSUE, because the previous operation's RD may still be high.
REQ-017 SHALL, on the first WAIT cycle with RD=1, capture RES into RSP_DATA, set RSP_VALID and RSP_ERR=0, and go to HOLD.
REQ-018 SHALL hold RSP_VALID/RSP_DATA/RSP_ERR stable in HOLD until RSP_VALID&&RSP_READY, then clear RSP_VALID and go to IDLE.
REQ-019 SHALL allow a push accepted in cycle N to raise ST no earlier than cycle N+2, which is the minimum latency.
REQ-020 SHALL allow a FIFO push in any state.
REQ-021 SHALL allow only one operation outstanding.

Reset
REQ-022 SHALL, while RST_N=0, immediately force the FSM to IDLE and set the FIFO empty.
REQ-023 SHALL, while RST_N=0, force ST=0, IN0=IN1=0, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, BUSY=0, REQ_READY=0.
REQ-024 SHALL, on reset mid-operation, discard any in-flight result, ignore a later RD, and raise REQ_READY on the first edge after release.

Configuration
REQ-025 SHALL, with OP_INITIATOR_TIMEOUT_EN defined, count WAIT cycles.
REQ-026 SHALL, with OP_INITIATOR_TIMEOUT_EN defined, go to HOLD with RSP_VALID=1, RSP_ERR=1 and RSP_DATA=0 after TIMEOUT cycles without RD.
REQ-027 SHALL, with OP_INITIATOR_TIMEOUT_EN defined, give RD precedence when RD and expiry occur in the same cycle.
REQ-028 SHALL, without OP_INITIATOR_TIMEOUT_EN, contain no counter, wait in WAIT indefinitely, and tie RSP_ERR to 0.

Structure
REQ-029 SHALL place FSM state encodings and the default BW/DEPTH constants in shared package op_pkg.
REQ-030 SHALL implement the FIFO as sub-module op_fifo with push/pop/full/empty.

Verification
REQ-031 SHALL cover: push (4,5), multiplier model RD after 10 cycles -> one ST pulse, IN0=4, IN1=5 held, RSP_DATA=20, RSP_ERR=0.
REQ-032 SHALL cover: push 5 pairs back-to-back with DEPTH=4 -> REQ_READY low after 4 accepted, 5th accepted after first pop, results in order.
REQ-033 SHALL cover: RSP_READY held low for 20 cycles -> RSP_VALID/RSP_DATA stable, no new ST until handshake.
REQ-034 SHALL cover: RD held high from previous op across ISSUE -> not taken as completion, waits for next RD rising in WAIT.
REQ-035 SHALL cover: RST_N low during WAIT, then RD pulse -> no RSP_VALID, FIFO empty, ST low.
REQ-036 SHALL cover: with OP_INITIATOR_TIMEOUT_EN and TIMEOUT=8, RD never asserted -> RSP_ERR=1 and RSP_DATA=0 after 8 WAIT cycles.
